// File: rtl/register.sv
// ============================================================================
// Module   : register
// Purpose  : Memory-mapped control/status register file for GPIO and timer
//            peripherals. Optional macro REGISTER_GPIO_IRQ_EN adds the
//            GPIO_INTSTATUS register (addr 8) and drives gpio_irq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic [3:0]  wben,
    input  logic        r_wn,
    input  logic [31:0] wdata,
    input  logic [15:0] ro_gpio_pinstate,
    input  logic        ro_status,
    input  logic [31:0] ro_currcount,
    output logic [31:0] rdata,
    output logic [15:0] rf_gpio_datareg,
    output logic [15:0] rf_gpio_tristate,
    output logic [15:0] rf_gpio_interrupt_mask,
    output logic        rf_mode,
    output logic [31:0] rf_termcount,
    output logic        rf_trig_start,
    output logic        rf_trig_halt,
    output logic        gpio_irq
);

    localparam logic [3:0] c_ADDR_GPIO_DATA      = 4'd0;
    localparam logic [3:0] c_ADDR_GPIO_TRISTATE  = 4'd1;
    localparam logic [3:0] c_ADDR_GPIO_INTMASK   = 4'd2;
    localparam logic [3:0] c_ADDR_GPIO_PINSTATE  = 4'd3;
    localparam logic [3:0] c_ADDR_TIMER_CTRL     = 4'd4;
    localparam logic [3:0] c_ADDR_TIMER_TERM     = 4'd5;
    localparam logic [3:0] c_ADDR_TIMER_STATUS   = 4'd6;
    localparam logic [3:0] c_ADDR_TIMER_CURR     = 4'd7;
`ifdef REGISTER_GPIO_IRQ_EN
    localparam logic [3:0] c_ADDR_GPIO_INTSTATUS = 4'd8;
`endif

    function automatic logic [15:0] merge16(input logic [15:0] cur,
                                            input logic [15:0] nxt,
                                            input logic [1:0]  be);
        logic [15:0] res;
        for (int i = 0; i < 2; i++)
            res[8*i +: 8] = be[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        return res;
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] cur,
                                            input logic [31:0] nxt,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        return res;
    endfunction

    logic        w_wr;
    logic        w_ctrl_wr;
    logic [31:0] w_rdata_nxt;

    logic [15:0] r_gpio_data;
    logic [15:0] r_gpio_tristate;
    logic [15:0] r_gpio_intmask;
    logic        r_mode;
    logic [31:0] r_termcount;
    logic        r_trig_start;
    logic        r_trig_halt;
    logic [31:0] r_rdata;

    assign w_wr      = ~r_wn;
    assign w_ctrl_wr = w_wr && (addr == c_ADDR_TIMER_CTRL) && wben[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio_data     <= 16'h0000;
            r_gpio_tristate <= 16'hFFFF;
            r_gpio_intmask  <= 16'h0000;
            r_mode          <= 1'b0;
            r_termcount     <= 32'h0000_0000;
        end else if (w_wr) begin
            case (addr)
                c_ADDR_GPIO_DATA:     r_gpio_data     <= merge16(r_gpio_data, wdata[15:0], wben[1:0]);
                c_ADDR_GPIO_TRISTATE: r_gpio_tristate <= merge16(r_gpio_tristate, wdata[15:0], wben[1:0]);
                c_ADDR_GPIO_INTMASK:  r_gpio_intmask  <= merge16(r_gpio_intmask, wdata[15:0], wben[1:0]);
                c_ADDR_TIMER_CTRL:    if (wben[0]) r_mode <= wdata[0];
                c_ADDR_TIMER_TERM:    r_termcount     <= merge32(r_termcount, wdata, wben);
                default: ;
            endcase
        end
    end

    // Triggers re-evaluate every cycle, so each qualifying write yields exactly
    // one pulse; halt takes priority when both bits are set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trig_start <= 1'b0;
            r_trig_halt  <= 1'b0;
        end else begin
            r_trig_start <= w_ctrl_wr & wdata[1] & ~wdata[2];
            r_trig_halt  <= w_ctrl_wr & wdata[2];
        end
    end

`ifdef REGISTER_GPIO_IRQ_EN
    logic [15:0] r_pin_prev;
    logic [15:0] r_int_status;
    logic [15:0] w_pin_event;
    logic [15:0] w_int_clr;

    assign w_pin_event = (ro_gpio_pinstate ^ r_pin_prev) & r_gpio_intmask;
    assign w_int_clr   = (w_wr && (addr == c_ADDR_GPIO_INTSTATUS))
                       ? {wben[1] ? wdata[15:8] : 8'h00, wben[0] ? wdata[7:0] : 8'h00}
                       : 16'h0000;

    // A new event overrides a same-cycle clear so no edge is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pin_prev   <= 16'h0000;
            r_int_status <= 16'h0000;
        end else begin
            r_pin_prev   <= ro_gpio_pinstate;
            r_int_status <= (r_int_status & ~w_int_clr) | w_pin_event;
        end
    end

    assign gpio_irq = |r_int_status;
`else
    assign gpio_irq = 1'b0;
`endif

    always_comb begin
        w_rdata_nxt = 32'h0000_0000;
        case (addr)
            c_ADDR_GPIO_DATA:      w_rdata_nxt = {16'h0000, r_gpio_data};
            c_ADDR_GPIO_TRISTATE:  w_rdata_nxt = {16'h0000, r_gpio_tristate};
            c_ADDR_GPIO_INTMASK:   w_rdata_nxt = {16'h0000, r_gpio_intmask};
            c_ADDR_GPIO_PINSTATE:  w_rdata_nxt = {16'h0000, ro_gpio_pinstate};
            c_ADDR_TIMER_CTRL:     w_rdata_nxt = {31'h0, r_mode};
            c_ADDR_TIMER_TERM:     w_rdata_nxt = r_termcount;
            c_ADDR_TIMER_STATUS:   w_rdata_nxt = {31'h0, ro_status};
            c_ADDR_TIMER_CURR:     w_rdata_nxt = ro_currcount;
`ifdef REGISTER_GPIO_IRQ_EN
            c_ADDR_GPIO_INTSTATUS: w_rdata_nxt = {16'h0000, r_int_status};
`endif
            default:               w_rdata_nxt = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rdata <= 32'h0000_0000;
        else if (r_wn)
            r_rdata <= w_rdata_nxt;
    end

    assign rdata                  = r_rdata;
    assign rf_gpio_datareg        = r_gpio_data;
    assign rf_gpio_tristate       = r_gpio_tristate;
    assign rf_gpio_interrupt_mask = r_gpio_intmask;
    assign rf_mode                = r_mode;
    assign rf_termcount           = r_termcount;
    assign rf_trig_start          = r_trig_start;
    assign rf_trig_halt           = r_trig_halt;

endmodule

`default_nettype wire

// File: tb/tb_register.sv
// ============================================================================
// Module   : tb_register
// Purpose  : Directed, table-driven self-checking bench for register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register;

    logic        clk;
    logic        reset;
    logic [3:0]  addr;
    logic [3:0]  wben;
    logic        r_wn;
    logic [31:0] wdata;
    logic [15:0] ro_gpio_pinstate;
    logic        ro_status;
    logic [31:0] ro_currcount;
    logic [31:0] rdata;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_interrupt_mask;
    logic        rf_mode;
    logic [31:0] rf_termcount;
    logic        rf_trig_start;
    logic        rf_trig_halt;
    logic        gpio_irq;

    int checks;
    int failures;

    register dut (
        .clk                    (clk),
        .reset                  (reset),
        .addr                   (addr),
        .wben                   (wben),
        .r_wn                   (r_wn),
        .wdata                  (wdata),
        .ro_gpio_pinstate       (ro_gpio_pinstate),
        .ro_status              (ro_status),
        .ro_currcount           (ro_currcount),
        .rdata                  (rdata),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask),
        .rf_mode                (rf_mode),
        .rf_termcount           (rf_termcount),
        .rf_trig_start          (rf_trig_start),
        .rf_trig_halt           (rf_trig_halt),
        .gpio_irq               (gpio_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  waddr;
        logic [3:0]  wben;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        r_wn = 1'b0;
        wben = 4'h0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        addr = a; wben = be; wdata = d; r_wn = 1'b0;
        @(negedge clk);
        idle();
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; r_wn = 1'b1; wben = 4'h0;
        @(negedge clk);
        idle();
        d = rdata;
    endtask

    vec_t        vecs [16];
    logic [31:0] got;
    logic [31:0] held;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; addr = 4'h0; wben = 4'h0; r_wn = 1'b0; wdata = 32'h0;
        ro_gpio_pinstate = 16'h0000; ro_status = 1'b0; ro_currcount = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_tristate", {16'h0, rf_gpio_tristate}, 32'h0000FFFF);
        check("rst_outs", {rf_gpio_datareg, rf_gpio_interrupt_mask}, 32'h0);
        check("rst_term", rf_termcount, 32'h0);
        check("rst_bits", {28'h0, rf_mode, rf_trig_start, rf_trig_halt, gpio_irq}, 32'h0);
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), got);
            check($sformatf("rst_read_a%0d", a), got, (a == 1) ? 32'h0000FFFF : 32'h0);
        end

        // Cumulative write-then-read vectors from reset state
        ro_gpio_pinstate = 16'h3C3C; ro_status = 1'b0; ro_currcount = 32'h01234567;
        vecs[0]  = '{4'd5,  4'b0101, 32'h11223344, 4'd5,  32'h00220044};
        vecs[1]  = '{4'd0,  4'b1111, 32'hCAFEBABE, 4'd0,  32'h0000BABE};
        vecs[2]  = '{4'd0,  4'b0010, 32'h00001200, 4'd0,  32'h000012BE};
        vecs[3]  = '{4'd0,  4'b0000, 32'hFFFFFFFF, 4'd0,  32'h000012BE};
        vecs[4]  = '{4'd1,  4'b0001, 32'h0000005A, 4'd1,  32'h0000FF5A};
        vecs[5]  = '{4'd2,  4'b1100, 32'hFFFF0000, 4'd2,  32'h00000000};
        vecs[6]  = '{4'd2,  4'b0011, 32'h00008001, 4'd2,  32'h00008001};
        vecs[7]  = '{4'd3,  4'b1111, 32'h00001234, 4'd3,  32'h00003C3C};
        vecs[8]  = '{4'd5,  4'b1010, 32'hAABBCCDD, 4'd5,  32'hAA22CC44};
        vecs[9]  = '{4'd9,  4'b1111, 32'hFFFFFFFF, 4'd9,  32'h00000000};
        vecs[10] = '{4'd15, 4'b1111, 32'hFFFFFFFF, 4'd15, 32'h00000000};
        vecs[11] = '{4'd6,  4'b1111, 32'hFFFFFFFF, 4'd6,  32'h00000000};
        vecs[12] = '{4'd7,  4'b1111, 32'hFFFFFFFF, 4'd7,  32'h01234567};
        vecs[13] = '{4'd8,  4'b1111, 32'hFFFFFFFF, 4'd8,  32'h00000000};
        vecs[14] = '{4'd4,  4'b0001, 32'hFFFFFFF1, 4'd4,  32'h00000001};
        vecs[15] = '{4'd13, 4'b1111, 32'hFFFFFFFF, 4'd1,  32'h0000FF5A};
        for (int i = 0; i < 16; i++) begin
            do_write(vecs[i].waddr, vecs[i].wben, vecs[i].wdata);
            do_read(vecs[i].raddr, got);
            check($sformatf("vec%0d_a%0d", i, vecs[i].raddr), got, vecs[i].exp);
        end
        check("term_port", rf_termcount, 32'hAA22CC44);
        do_write(4'd4, 4'b0001, 32'h0);
        do_read(4'd4, got);
        check("ctrl_mode0", got, 32'h0);

        // RO pass-through
        ro_gpio_pinstate = 16'hA5A5; ro_currcount = 32'hDEADBEEF; ro_status = 1'b1;
        do_read(4'd3, got); check("ro_pin", got, 32'h0000A5A5);
        do_read(4'd7, got); check("ro_curr", got, 32'hDEADBEEF);
        do_read(4'd6, got); check("ro_status", got, 32'h1);

        // Triggers
        do_write(4'd4, 4'b1111, 32'h3);
        check("trig3_start", {30'h0, rf_trig_start, rf_trig_halt}, 32'h2);
        check("trig3_mode", {31'h0, rf_mode}, 32'h1);
        @(negedge clk);
        check("trig3_clear", {30'h0, rf_trig_start, rf_trig_halt}, 32'h0);
        do_write(4'd4, 4'b0001, 32'h6);
        check("trig6_halt", {30'h0, rf_trig_start, rf_trig_halt}, 32'h1);
        check("trig6_mode", {31'h0, rf_mode}, 32'h0);
        @(negedge clk);
        check("trig6_clear", {30'h0, rf_trig_start, rf_trig_halt}, 32'h0);
        do_write(4'd4, 4'b1110, 32'h2);
        check("trig_nobe0", {30'h0, rf_trig_start, rf_trig_halt}, 32'h0);
        @(negedge clk);
        addr = 4'd4; wben = 4'b0001; wdata = 32'h2; r_wn = 1'b0;
        @(negedge clk);
        check("b2b_1", {30'h0, rf_trig_start, rf_trig_halt}, 32'h2);
        @(negedge clk);
        idle();
        check("b2b_2", {30'h0, rf_trig_start, rf_trig_halt}, 32'h2);
        @(negedge clk);
        check("b2b_3", {30'h0, rf_trig_start, rf_trig_halt}, 32'h0);
        do_read(4'd4, got);
        check("ctrl_read", got, 32'h0);

        // Read hold
        do_read(4'd0, held);
        check("hold_first", held, 32'h000012BE);
        do_write(4'd0, 4'b0011, 32'h00007777);
        do_write(4'd5, 4'b1111, 32'h55555555);
        check("hold_rdata", rdata, 32'h000012BE);
        do_read(4'd0, got);
        check("hold_new", got, 32'h00007777);

        // Reset asserted during a write aborts it
        @(negedge clk);
        addr = 4'd0; wben = 4'hF; wdata = 32'hFFFFFFFF; r_wn = 1'b0;
        #1 reset = 1'b0;
        #1 check("async_tristate", {16'h0, rf_gpio_tristate}, 32'h0000FFFF);
        @(posedge clk); #1;
        check("abort_data", {16'h0, rf_gpio_datareg}, 32'h0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        do_read(4'd0, got); check("abort_read0", got, 32'h0);
        do_read(4'd5, got); check("abort_read5", got, 32'h0);

`ifdef REGISTER_GPIO_IRQ_EN
        ro_gpio_pinstate = 16'h0000;
        do_write(4'd2, 4'b0011, 32'h0001);
        do_write(4'd8, 4'b0011, 32'hFFFF);
        check("irq_idle", {31'h0, gpio_irq}, 32'h0);
        @(negedge clk); ro_gpio_pinstate = 16'h0001;
        @(negedge clk);
        check("irq_set", {31'h0, gpio_irq}, 32'h1);
        do_read(4'd8, got); check("irq_status", got, 32'h1);
        do_write(4'd8, 4'b0001, 32'h1);
        check("irq_clear", {31'h0, gpio_irq}, 32'h0);
        @(negedge clk);
        ro_gpio_pinstate = 16'h0003;
        repeat (2) @(negedge clk);
        check("irq_unmasked", {31'h0, gpio_irq}, 32'h0);
        @(negedge clk);
        ro_gpio_pinstate = 16'h0002;
        addr = 4'd8; wben = 4'b0001; wdata = 32'h1; r_wn = 1'b0;
        @(negedge clk);
        idle();
        check("irq_set_wins", {31'h0, gpio_irq}, 32'h1);
`else
        ro_gpio_pinstate = 16'hFFFF;
        do_write(4'd2, 4'b0011, 32'hFFFF);
        ro_gpio_pinstate = 16'h0000;
        repeat (2) @(negedge clk);
        check("irq_tied", {31'h0, gpio_irq}, 32'h0);
        do_read(4'd8, got); check("a8_reserved", got, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register.md
Name: register

Overview:
- Memory-mapped control/status register file for the RISC-V microcontroller peripheral bus.
- Decodes a 4-bit word address with byte enables and a read/write strobe.
- Drives GPIO configuration and timer configuration/trigger fields to the peripherals.
- Returns the peripherals' read-only state (GPIO pin state, timer status, current count) on rdata.

Parameters:
- None. All widths fixed: GPIO 16 bits, timer 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  4 [5:2]  word address.
- wben  in  4  byte write enables; bit i covers wdata[8i+7:8i].
- r_wn  in  1  1 = read, 0 = write.
- wdata  in  32  write data.
- ro_gpio_pinstate  in  16  sampled GPIO pin levels.
- ro_status  in  1  timer running status.
- ro_currcount  in  32  timer current count.
- rdata  out  32  read data.
- rf_gpio_datareg  out  16  GPIO output data.
- rf_gpio_tristate  out  16  GPIO tristate; 1 = pin is input.
- rf_gpio_interrupt_mask  out  16  GPIO interrupt enables.
- rf_mode  out  1  timer mode (0 one-shot, 1 continuous).
- rf_termcount  out  32  timer terminal count.
- rf_trig_start  out  1  one-cycle timer start pulse.
- rf_trig_halt  out  1  one-cycle timer halt pulse.
- gpio_irq  out  1  GPIO interrupt (optional feature).

Behaviour:
- Address map (addr value / register):
  - 0: GPIO_DATA, RW [15:0]
  - 1: GPIO_TRISTATE, RW [15:0]
  - 2: GPIO_INTMASK, RW [15:0]
  - 3: GPIO_PINSTATE, RO [15:0]
  - 4: TIMER_CTRL; bit0 mode RW, bit1 START write-only, bit2 HALT write-only
  - 5: TIMER_TERMCOUNT, RW [31:0]
  - 6: TIMER_STATUS, RO bit0
  - 7: TIMER_CURRCOUNT, RO [31:0]
  - 8: GPIO_INTSTATUS (optional feature only)
  - 9–15: reserved
- Write: on a rising clk with r_wn=0, each byte whose wben bit is 1 is updated.
  - wben=0 means no change.
  - Bytes beyond a register's width are ignored.
  - Writes to RO or reserved addresses are ignored.
- Read: on a rising clk with r_wn=1, rdata is loaded with the addressed register, zero-extended. One-cycle latency.
  - rdata holds its value while r_wn=0.
  - Reserved addresses read 0.
  - TIMER_CTRL reads {29'b0, 0, 0, mode}; trigger bits always read 0.
- RO registers return the input value sampled at the read edge.
- Triggers: a write to addr 4 with wben[0]=1 and wdata[1]=1 drives rf_trig_start=1 for exactly the next cycle. wdata[2] does the same for rf_trig_halt.
  - If both bits are set in one write, only halt pulses.
  - Pulses self-clear after one cycle; back-to-back writes give back-to-back pulses.
- The mode bit updates from wdata[0] on the same write as a trigger.
- Reset (reset=0, asynchronous): rdata, all rf_* outputs, triggers and gpio_irq go to 0. Exception: rf_gpio_tristate goes to 16'hFFFF (all pins input).
- Reset asserted during an access aborts it; no partial update survives.

Optional Feature:
- Macro: REGISTER_GPIO_IRQ_EN.
- When defined:
  - GPIO_INTSTATUS (addr 8) bit i is set when ro_gpio_pinstate[i] changes between consecutive clks and rf_gpio_interrupt_mask[i]=1.
  - Bits are sticky; writing 1 to a bit clears it (write-1-to-clear, byte-enabled).
  - A set event in the same cycle as a clear wins.
  - gpio_irq is the OR of all status bits.
  - The status register and the pinstate history reset to 0.
- When undefined: addr 8 is reserved (reads 0, writes ignored) and gpio_irq is tied to 0.

Test Plan:
- Reset: reset=0 then 1 → all RW reads 0, except addr 1 reads 32'h0000FFFF; rdata=0.
- Write-then-read sweep: for addr 0..13, with wben swept from 0 to 15, write wdata=addr, then read every address back.
  - Only enabled bytes change; RO/reserved addresses are unaffected.
  - Example: addr 5 written with wben=4'b0101 and data 32'h11223344 → reads 32'h00220044 from reset.
- RO pass-through: ro_gpio_pinstate=16'hA5A5, ro_currcount=32'hDEADBEEF, ro_status=1 → reads return 32'h0000A5A5, 32'hDEADBEEF and 1 respectively.
- Triggers:
  - Write 32'h3 to addr 4 → rf_mode=1, rf_trig_start high for one cycle.
  - Write 32'h6 → only rf_trig_halt pulses.
  - A read of addr 4 returns 0 or 1 (mode bit only).
- Read hold: a read of addr 0 followed by writes leaves rdata unchanged until the next read.
- With REGISTER_GPIO_IRQ_EN:
  - Mask 16'h0001, toggle pin0 → gpio_irq=1 and addr 8 reads 1.
  - Write 1 to addr 8 → gpio_irq=0.
  - Toggling pin1 (unmasked) → no interrupt.
